// File: rtl/subtrator_serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
// FSM state encodings, default width and counter sizing.
package subtrator_serial_pkg;

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        CALCULANDO = 2'd1,
        CONCLUIDO  = 2'd2
    } estado_t;

    localparam int N_PADRAO = 4;

    // Bit counter width; never narrower than one bit so N = 1 still works.
    function automatic int cnt_largura(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/meio_subtrator.sv
// Half subtractor: d = a - b, bout = borrow.
// Building block of the full-subtractor cell.
module meio_subtrator (
    input  logic a_i,
    input  logic b_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i;
    assign bout_o = ~a_i & b_i;

endmodule

// File: rtl/subtrator_completo.sv
// Full subtractor from two half subtractors and an OR.
// Reusable by a ripple subtractor as well as the serial one.
module subtrator_completo (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    logic d1;
    logic b1;
    logic b2;

    meio_subtrator u_ms1 (
        .a_i    (a_i),
        .b_i    (b_i),
        .d_o    (d1),
        .bout_o (b1)
    );

    meio_subtrator u_ms2 (
        .a_i    (d1),
        .b_i    (bin_i),
        .d_o    (d_o),
        .bout_o (b2)
    );

    assign bout_o = b1 | b2;

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit unsigned subtractor, LSB first.
// One full-subtractor cell reused over N cycles with a start/done handshake.
module subtrator_serial
    import subtrator_serial_pkg::*;
#(
    parameter int N = N_PADRAO
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inicio,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] D,
    output logic         C_out,
    output logic         ocupado,
    output logic         pronto
);

    localparam int CW = cnt_largura(N);

    estado_t       estado_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  res_q;
    logic [N-1:0]  res_d;
    logic [CW-1:0] cnt_q;
    logic          borrow_q;
    logic [N-1:0]  d_q;
    logic          cout_q;
    logic          ocupado_q;
    logic          pronto_q;
    logic          bit_d;
    logic          bout;
    logic          ultimo;

    subtrator_completo u_cell (
        .a_i    (a_q[0]),
        .b_i    (b_q[0]),
        .bin_i  (borrow_q),
        .d_o    (bit_d),
        .bout_o (bout)
    );

    // New difference bit enters at the MSB; after N shifts bit k sits at k.
    always_comb begin
        res_d      = res_q >> 1;
        res_d[N-1] = bit_d;
        ultimo     = (cnt_q == CW'(N - 1));
    end

    // FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= OCIOSO;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            borrow_q  <= 1'b0;
            d_q       <= '0;
            cout_q    <= 1'b0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            unique case (estado_q)
                OCIOSO, CONCLUIDO: begin
                    pronto_q <= 1'b0;
                    if (inicio) begin
                        a_q       <= A;
                        b_q       <= B;
                        res_q     <= '0;
                        cnt_q     <= '0;
                        borrow_q  <= 1'b0;
                        ocupado_q <= 1'b1;
                        estado_q  <= CALCULANDO;
                    end else begin
                        estado_q  <= OCIOSO;
                    end
                end
                CALCULANDO: begin
                    res_q    <= res_d;
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    borrow_q <= bout;
                    cnt_q    <= cnt_q + CW'(1);
                    if (ultimo) begin
                        d_q       <= res_d;
                        cout_q    <= bout;
                        cnt_q     <= '0;
                        ocupado_q <= 1'b0;
                        pronto_q  <= 1'b1;
                        estado_q  <= CONCLUIDO;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign D       = d_q;
    assign C_out   = cout_q;
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial (N = 4 and N = 1).
// Expected results are queued at start and compared on pronto.
module tb_subtrator_serial;

    logic       clk;
    logic       rst;
    logic       inicio4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [3:0] d4;
    logic       c4;
    logic       ocup4;
    logic       pr4;
    logic       inicio1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [0:0] d1;
    logic       c1;
    logic       ocup1;
    logic       pr1;

    int vectors;
    int miscompares;

    logic [4:0] q4[$];
    logic [1:0] q1[$];

    subtrator_serial #(.N(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .inicio  (inicio4),
        .A       (a4),
        .B       (b4),
        .D       (d4),
        .C_out   (c4),
        .ocupado (ocup4),
        .pronto  (pr4)
    );

    subtrator_serial #(.N(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .inicio  (inicio1),
        .A       (a1),
        .B       (b1),
        .D       (d1),
        .C_out   (c1),
        .ocupado (ocup1),
        .pronto  (pr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] d;
        d = a - b;
        return {(a < b), d};
    endfunction

    // Present operands at the current negedge and queue the expected result.
    task automatic drive4(input logic [3:0] a, input logic [3:0] b);
        a4      = a;
        b4      = b;
        inicio4 = 1'b1;
        q4.push_back(ref4(a, b));
    endtask

    // Step negedges until pronto; report cycles taken and ocupado cycles seen.
    task automatic wait4(input bit hold, output int lat, output int busy);
        lat  = 0;
        busy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!hold) inicio4 = 1'b0;
            if (ocup4) busy++;
        end while (!pr4 && lat < 20);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        inicio4 = 1'b0;
        inicio1 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; a1 = 1'b0; b1 = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({d4, c4, ocup4, pr4} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset4 got %b want 0000000", {d4, c4, ocup4, pr4});
        end
        vectors++;
        if ({d1, c1, ocup1, pr1} !== 4'd0) begin
            miscompares++;
            $display("FAIL reset1 got %b want 0000", {d1, c1, ocup1, pr1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lat, busy;
        logic [4:0] e;
        drive4(4'd9, 4'd3);
        wait4(1'b0, lat, busy);
        vectors++;
        if (lat !== 5) begin
            miscompares++;
            $display("FAIL latency got %0d want 5", lat);
        end
        vectors++;
        if (busy !== 4) begin
            miscompares++;
            $display("FAIL ocupado_cycles got %0d want 4", busy);
        end
        e = q4.pop_front();
        vectors++;
        if ({c4, d4} !== e) begin
            miscompares++;
            $display("FAIL 9-3 got c=%b d=%0d want c=%b d=%0d", c4, d4, e[4], e[3:0]);
        end
        @(negedge clk);
        vectors++;
        if (pr4 !== 1'b0) begin
            miscompares++;
            $display("FAIL pronto_width got %b want 0", pr4);
        end
    endtask

    task automatic test_borrow();
        logic [3:0] ta[3];
        logic [3:0] tb[3];
        logic [4:0] want[3];
        int lat, busy;
        logic [4:0] e;
        ta = '{4'd3, 4'd0, 4'd15};
        tb = '{4'd9, 4'd1, 4'd15};
        want = '{5'b1_1010, 5'b1_1111, 5'b0_0000};
        for (int i = 0; i < 3; i++) begin
            drive4(ta[i], tb[i]);
            wait4(1'b0, lat, busy);
            e = q4.pop_front();
            vectors++;
            if ({c4, d4} !== want[i] || e !== want[i]) begin
                miscompares++;
                $display("FAIL borrow%0d got c=%b d=%0d want c=%b d=%0d",
                         i, c4, d4, want[i][4], want[i][3:0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, busy, prs;
        logic [4:0] e;
        prs = 0;
        drive4(4'd12, 4'd5);
        for (int i = 0; i < 5; i++) begin
            wait4(1'b1, lat, busy);
            e = q4.pop_front();
            if (pr4) prs++;
            vectors++;
            if (lat !== 5 || {c4, d4} !== e) begin
                miscompares++;
                $display("FAIL b2b%0d got lat=%0d c=%b d=%0d want lat=5 c=%b d=%0d",
                         i, lat, c4, d4, e[4], e[3:0]);
            end
            if (i < 4) drive4(4'(i * 3 + 1), 4'(i * 5 + 2));
            else inicio4 = 1'b0;
        end
        @(negedge clk);
        vectors++;
        if (prs !== 5 || pr4 !== 1'b0 || q4.size() !== 0) begin
            miscompares++;
            $display("FAIL b2b_count got %0d pronto=%b q=%0d want 5 0 0",
                     prs, pr4, q4.size());
        end
    endtask

    task automatic test_ignore_inicio();
        int lat, extra;
        logic [4:0] e;
        drive4(4'd13, 4'd6);
        @(negedge clk);
        inicio4 = 1'b0;
        @(negedge clk);
        a4 = 4'd1; b4 = 4'd8; inicio4 = 1'b1;
        @(negedge clk);
        inicio4 = 1'b0;
        a4 = 4'd2; b4 = 4'd2;
        lat = 0;
        while (!pr4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = q4.pop_front();
        vectors++;
        if ({c4, d4} !== e) begin
            miscompares++;
            $display("FAIL ignore got c=%b d=%0d want c=%b d=%0d", c4, d4, e[4], e[3:0]);
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (pr4) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL ignore_extra got %0d pronto want 0", extra);
        end
    endtask

    task automatic test_abort();
        int lat, busy, extra;
        logic [4:0] e;
        drive4(4'd10, 4'd4);
        @(negedge clk);
        inicio4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({d4, c4, ocup4, pr4} !== 7'd0) begin
            miscompares++;
            $display("FAIL abort got %b want 0000000", {d4, c4, ocup4, pr4});
        end
        rst = 1'b0;
        q4.delete();
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (pr4 || ocup4) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL abort_quiet got %0d active cycles want 0", extra);
        end
        drive4(4'd7, 4'd11);
        wait4(1'b0, lat, busy);
        e = q4.pop_front();
        vectors++;
        if (lat !== 5 || {c4, d4} !== e) begin
            miscompares++;
            $display("FAIL after_abort got lat=%0d c=%b d=%0d want lat=5 c=%b d=%0d",
                     lat, c4, d4, e[4], e[3:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep4();
        int lat, busy;
        logic [4:0] e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive4(4'(a), 4'(b));
                wait4(1'b0, lat, busy);
                e = q4.pop_front();
                vectors++;
                if (!pr4 || {c4, d4} !== e) begin
                    miscompares++;
                    $display("FAIL sweep4 %0d-%0d got p=%b c=%b d=%0d want c=%b d=%0d",
                             a, b, pr4, c4, d4, e[4], e[3:0]);
                end
            end
        end
    endtask

    task automatic test_sweep1();
        int lat;
        logic [1:0] e;
        for (int a = 0; a < 2; a++) begin
            for (int b = 0; b < 2; b++) begin
                a1 = 1'(a);
                b1 = 1'(b);
                inicio1 = 1'b1;
                q1.push_back({(a < b), 1'(a - b)});
                lat = 0;
                do begin
                    @(negedge clk);
                    lat++;
                    inicio1 = 1'b0;
                end while (!pr1 && lat < 20);
                e = q1.pop_front();
                vectors++;
                if (lat !== 2 || {c1, d1} !== e) begin
                    miscompares++;
                    $display("FAIL sweep1 %0d-%0d got lat=%0d c=%b d=%b want lat=2 c=%b d=%b",
                             a, b, lat, c1, d1, e[1], e[0]);
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_borrow();
        test_back_to_back();
        test_ignore_inicio();
        test_abort();
        test_sweep4();
        test_sweep1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
